// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round constants, GF(2^8) helpers, scheduler states.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package aes_pkg;

    localparam int NR = 10;   // AES-128 round count
    localparam int NK = 4;    // key length in 32-bit words

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Round constant byte for rounds 1..10; zero for any other round number.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (round r-1 -> r) or inverse (r -> r-1).
// Latency: combinational.
// Backpressure: none.
// Ports: key_i current round key (word 0 in [127:96]), rcon_i round constant byte,
//        dir_i 0=forward 1=inverse, key_o next key.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         dir_i,
    output logic [127:0] key_o
);

    logic [31:0] a0, a1, a2, a3;
    logic [31:0] sb_src, rot_w, sub_w, f_w;
    logic [31:0] b0, b1, b2, b3;

    assign {a0, a1, a2, a3} = key_i;

    // Going backward, the previous round's last word is a3^a2, so the single
    // SBox bank is fed from that instead of a3.
    assign sb_src = dir_i ? (a3 ^ a2) : a3;
    assign rot_w  = {sb_src[23:0], sb_src[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot_w[8*g +: 8]),
            .out_o (sub_w[8*g +: 8])
        );
    end

    assign f_w = sub_w ^ {rcon_i, 24'h000000};

    always_comb begin
        if (dir_i) begin
            b3 = a3 ^ a2;
            b2 = a2 ^ a1;
            b1 = a1 ^ a0;
            b0 = a0 ^ f_w;
        end else begin
            b0 = a0 ^ f_w;
            b1 = a1 ^ b0;
            b2 = a2 ^ b1;
            b3 = a3 ^ b2;
        end
    end

    assign key_o = {b0, b1, b2, b3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Latency: combinational.
// Backpressure: none.
// Ports: in_i byte in, out_o substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] inv;

    // inv = in_i^254 by square-and-multiply over exponent 8'b1111_1110;
    // 0 maps to 0, which is exactly what the S-box needs.
    always_comb begin
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, in_i);
        end
    end

    assign out_o = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// AES-128 decryption key scheduler: emits round keys 10 down to 0 from one key register.
// Latency: key_valid rises 10 edges after start is accepted; then one key per handshake.
// Backpressure: round_key/round_idx held stable while key_ready=0; start ignored when busy.
// Ports: clk, reset (async active-high), start/key_in request, key_valid/key_ready/
//        round_key/round_idx output handshake, busy, done (one-cycle pulse at end).
// Build option: AES_INV_MIX_KEY_EN applies InvMixColumns to round keys 1..9.
module aes_inv_key_scheduler
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;     // FWD: next round to compute; EMIT: round held in key_q
    logic         done_q, done_d;

    logic [127:0] step_key;
    logic [7:0]   step_rcon;
    logic         step_dir;

    // The counter doubles as rcon index in both phases, so no extra mux is needed.
    assign step_rcon = rcon(cnt_q);
    assign step_dir  = (state_q == EMIT);

    aes_key_step u_step (
        .key_i  (key_q),
        .rcon_i (step_rcon),
        .dir_i  (step_dir),
        .key_o  (step_key)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    cnt_d   = 4'd1;
                    state_d = FWD;
                end
            end
            FWD: begin
                key_d = step_key;
                // Counter stays at NR on the last step: it becomes the first emitted index.
                if (cnt_q == 4'(NR)) state_d = EMIT;
                else                 cnt_d   = cnt_q + 4'd1;
            end
            EMIT: begin
                if (key_ready) begin
                    if (cnt_q != 4'd0) begin
                        key_d = step_key;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign key_valid = (state_q == EMIT);
    assign round_idx = cnt_q;
    assign done      = done_q;

`ifdef AES_INV_MIX_KEY_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
                gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
                gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
                gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
    endfunction

    logic [127:0] mixed_key;
    logic         mix_sel;

    assign mixed_key = {inv_mix_col(key_q[127:96]), inv_mix_col(key_q[95:64]),
                        inv_mix_col(key_q[63:32]),  inv_mix_col(key_q[31:0])};
    // Only the middle rounds are mixed; key_q itself stays plain for the backward walk.
    assign mix_sel   = (state_q == EMIT) && (cnt_q != 4'd0) && (cnt_q != 4'(NR));
    assign round_key = mix_sel ? mixed_key : key_q;
`else
    assign round_key = key_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Directed bench for aes_inv_key_scheduler using FIPS-197 round keys.
// Latency: checks the 10-edge start-to-valid delay and the done pulse timing.
// Backpressure: exercises random key_ready stalls, held start and async reset aborts.
module tb_aes_inv_key_scheduler;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] fips_rk [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_inv_key_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] m_inv_mix(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   s0, s1, s2, s3;
        for (int c = 0; c < 4; c++) begin
            s0 = k[127 - 32*c -: 8];
            s1 = k[119 - 32*c -: 8];
            s2 = k[111 - 32*c -: 8];
            s3 = k[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = m_mul(s0, 8'h0e) ^ m_mul(s1, 8'h0b) ^ m_mul(s2, 8'h0d) ^ m_mul(s3, 8'h09);
            r[119 - 32*c -: 8] = m_mul(s0, 8'h09) ^ m_mul(s1, 8'h0e) ^ m_mul(s2, 8'h0b) ^ m_mul(s3, 8'h0d);
            r[111 - 32*c -: 8] = m_mul(s0, 8'h0d) ^ m_mul(s1, 8'h09) ^ m_mul(s2, 8'h0e) ^ m_mul(s3, 8'h0b);
            r[103 - 32*c -: 8] = m_mul(s0, 8'h0b) ^ m_mul(s1, 8'h0d) ^ m_mul(s2, 8'h09) ^ m_mul(s3, 8'h0e);
        end
        return r;
    endfunction

    // Expected round_key for a given index, given the plain schedule key.
    function automatic logic [127:0] exp_out(input int idx, input logic [127:0] plain);
`ifdef AES_INV_MIX_KEY_EN
        if (idx >= 1 && idx <= 9) return m_inv_mix(plain);
`endif
        return plain;
    endfunction

    // Caller is #1 after an edge with the DUT idle; the next edge accepts start.
    task automatic accept(input logic [127:0] k, input bit hold);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'd1);
    endtask

    // From the accept edge, key_valid must stay low for 9 edges and rise on the 10th.
    task automatic wait_emit();
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            chk("kv_early", 128'(key_valid), 128'd0);
        end
        @(posedge clk); #1;
        chk("kv_rise", 128'(key_valid), 128'd1);
        chk("idx_first", 128'(round_idx), 128'd10);
    endtask

    // Walk all 11 FIPS keys; every cycle checks the currently presented key.
    task automatic emit_all(input bit rnd);
        int exp_idx;
        int guard;
        exp_idx = 10;
        guard   = 0;
        while (exp_idx >= 0 && guard < 300) begin
            key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("emit_valid", 128'(key_valid), 128'd1);
            chk("emit_idx", 128'(round_idx), 128'(exp_idx));
            chk("emit_key", round_key, exp_out(exp_idx, fips_rk[exp_idx]));
            if (key_ready) exp_idx--;
            @(posedge clk); #1;
            guard++;
        end
        key_ready = 1'b0;
        chk("emit_in_budget", 128'(guard < 300), 128'd1);
        chk("done_pulse", 128'(done), 128'd1);
        chk("busy_end", 128'(busy), 128'd0);
        chk("kv_end", 128'(key_valid), 128'd0);
        chk("key_retained", round_key, fips_rk[0]);
        @(posedge clk); #1;
        chk("done_one_cycle", 128'(done), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_kv"}, 128'(key_valid), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_key"}, round_key, 128'd0);
        chk({tag, "_idx"}, 128'(round_idx), 128'd0);
    endtask

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset     = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        key_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Full schedule, consumer always ready.
        accept(FIPS_KEY, 1'b0);
        wait_emit();
        emit_all(1'b0);

        // Random backpressure.
        accept(FIPS_KEY, 1'b0);
        wait_emit();
        emit_all(1'b1);

        // start held high: one schedule, restart only once back in IDLE.
        accept(FIPS_KEY, 1'b1);
        wait_emit();
        emit_all(1'b0);
        chk("restart_busy", 128'(busy), 128'd1);
        chk("restart_not_valid", 128'(key_valid), 128'd0);
        start = 1'b0;
        wait_emit();
        emit_all(1'b0);

        // Abort in FWD after the counter reaches 5.
        accept(FIPS_KEY, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        chk("fwd5_busy", 128'(busy), 128'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("abort_fwd");
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Abort in EMIT at idx 6.
        accept(FIPS_KEY, 1'b0);
        wait_emit();
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        key_ready = 1'b0;
        chk("emit6_idx", 128'(round_idx), 128'd6);
        chk("emit6_key", round_key, exp_out(6, fips_rk[6]));
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("abort_emit");
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("no_done_after_abort", 128'(done), 128'd0);

        // All-zero key after aborts.
        accept(128'd0, 1'b0);
        wait_emit();
        chk("zero_r10", round_key, ZERO_R10);
        key_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            while (key_valid && guard < 40) begin
                if (round_idx == 4'd1) chk("zero_r1", round_key, exp_out(1, ZERO_R1));
                if (round_idx == 4'd0) chk("zero_r0", round_key, 128'd0);
                @(posedge clk); #1;
                guard++;
            end
            chk("zero_in_budget", 128'(guard), 128'd11);
        end
        key_ready = 1'b0;
        chk("zero_done", 128'(done), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_scheduler.md
Name: aes_inv_key_scheduler

Overview:
- Iterative AES-128 decryption key scheduler. It produces round keys in reverse order (round 10 down to round 0) for the decryption datapath.
- It loads the cipher key and runs the forward schedule for 10 cycles to reach round key 10. It then walks the schedule backward, one round per output handshake.
- Only one 128-bit key register is held; the 11 expanded keys are never stored.
- Sits between the key input and the inverse-cipher round engine.

Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; other values unsupported).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a schedule; sampled only in IDLE.
- key_in  input  128  cipher key, word 0 in [127:96]; sampled on the edge that accepts start.
- busy  output  1  high in every state except IDLE.
- key_valid  output  1  round_key/round_idx valid.
- key_ready  input  1  consumer accepts the current round key.
- round_key  output  128  current round key, word 0 in [127:96].
- round_idx  output  4  round number of round_key, counting 10 down to 0.
- done  output  1  one-cycle pulse after round key 0 is accepted.

Behaviour:
- Reset, asynchronous: state=IDLE, key register=0, counter=0, busy=0, key_valid=0, done=0, round_key=0, round_idx=0.
- States are IDLE, FWD and EMIT.
- IDLE:
  - start=1 loads key_in into the key register, sets cnt=1 and moves to FWD.
  - start is ignored in all other states; there is no queuing.
- FWD (busy=1, key_valid=0):
  - Each cycle: key <= fwd_round(key, rcon(cnt)); cnt <= cnt+1.
  - The update at cnt=10 moves to EMIT with idx=10.
  - If start is sampled at edge N, key_valid=1 after edge N+10.
- EMIT (key_valid=1):
  - round_key = key register; round_idx = idx.
  - Outputs are held stable while key_ready=0.
  - On key_valid&&key_ready with idx>0: key <= inv_round(key, rcon(idx)); idx <= idx-1. key_valid stays high, so back-to-back transfers run at one key per cycle.
  - On key_valid&&key_ready with idx==0: go to IDLE, key_valid=0, done=1 for exactly one cycle, round_key retains its last value.
- rcon(r) for r=1..10: 01,02,04,08,10,20,40,80,1b,36, placed in the top byte; any other r gives 0.
- Forward step, with words a0..a3:
  - b0 = a0 ^ SubWord(RotWord(a3)) ^ rcon.
  - bi = ai ^ b(i-1).
- Inverse step, from round r to r-1:
  - b3 = a3^a2, b2 = a2^a1, b1 = a1^a0.
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ rcon(r).
- RotWord moves the top byte to the bottom.
- One bank of 4 SBox instances is shared. The SBox input mux selects RotWord(a3) in FWD and RotWord(a3^a2) in EMIT.
- Reset asserted mid-FWD or mid-EMIT aborts immediately to IDLE with no done pulse.
- A start in the same cycle as the final handshake is ignored, because the state is still EMIT.

Optional Feature:
- Macro: AES_INV_MIX_KEY_EN.
- Defined: for round_idx 1..9, round_key = InvMixColumns(key register), applied per 32-bit column. This supports the equivalent inverse cipher.
  - round_idx 10 and 0 are output unmodified.
  - The internal register always holds the plain key, so the backward walk is unaffected.
- Undefined: round_key is always the plain key register; no InvMixColumns logic is present.

Decomposition:
- Package aes_pkg holds:
  - NR, NK=4.
  - A rcon(round) function.
  - xtime and gmul helper functions for InvMixColumns.
  - State enum constants IDLE/FWD/EMIT.
- Sub-module aes_key_step: combinational, inputs key, rcon and dir (0=forward, 1=inverse), output next key.
  - It contains the shared 4-SBox bank, reusing the existing SBox module.
- The scheduler holds only the FSM, counter, key register and handshake logic.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, key_ready=1 -> key_valid rises 10 edges after start. Key sequence:
   - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
   - idx9 = ac7766f319fadc2128d12941575c006e
   - idx1 = a0fafe1788542cb123a339392a6c7605
   - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
   - done pulses once, one cycle after the idx0 handshake.
2. Same key with key_ready toggled randomly -> round_key/round_idx stable while ready=0; identical sequence of 11 keys; no key skipped or repeated.
3. start held high throughout a run -> exactly one schedule; busy=1 from the edge after start until the edge after the idx0 handshake; the next run begins only after return to IDLE.
4. reset asserted at FWD cnt=5, and again in EMIT at idx=6 -> busy, key_valid and done go to 0 asynchronously; a new start with key 0 yields idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
5. With AES_INV_MIX_KEY_EN -> idx10 and idx0 equal the plain FIPS keys; idx1..9 equal the InvMixColumns of the plain keys, compared against a software model.
